// File: rtl/mult_seq.sv
// Multi-cycle MULT/MULTU sequencer: shift-add over a shared external adder,
// producing a 64-bit product into hi/lo. Signed operands go through magnitude form.
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, MUL, FIX_LO, FIX_HI, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m, m_nxt;
  logic [WIDTH-1:0]   q, q_nxt;
  logic [WIDTH-1:0]   acc_hi, acc_hi_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sgn, sgn_nxt;
  logic               neg, neg_nxt;
  logic               c, c_nxt;
  logic               busy_nxt;

  // State and datapath registers; hi/lo load only on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      q      <= '0;
      acc_hi <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      neg    <= 1'b0;
      c      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_nxt;
      m      <= m_nxt;
      q      <= q_nxt;
      acc_hi <= acc_hi_nxt;
      cnt    <= cnt_nxt;
      sgn    <= sgn_nxt;
      neg    <= neg_nxt;
      c      <= c_nxt;
      busy   <= busy_nxt;
      done   <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        hi <= acc_hi_nxt;
        lo <= q_nxt;
      end
    end
  end

  // Next-state, datapath updates and adder drive
  always_comb begin
    state_nxt  = state;
    m_nxt      = m;
    q_nxt      = q;
    acc_hi_nxt = acc_hi;
    cnt_nxt    = cnt;
    sgn_nxt    = sgn;
    neg_nxt    = neg;
    c_nxt      = c;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          m_nxt      = op_a;
          q_nxt      = op_b;
          sgn_nxt    = is_signed;
          neg_nxt    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_hi_nxt = '0;
          cnt_nxt    = '0;
          c_nxt      = 1'b0;
          state_nxt  = is_signed ? NEG_A : MUL;
        end
      end
      NEG_A: begin
        add_a   = ~m;
        add_cin = 1'b1;
        if (m[WIDTH-1]) m_nxt = add_sum;
        state_nxt = NEG_B;
      end
      NEG_B: begin
        add_a   = ~q;
        add_cin = 1'b1;
        if (q[WIDTH-1]) q_nxt = add_sum;
        state_nxt = MUL;
      end
      MUL: begin
        add_a = acc_hi;
        add_b = m;
        // {acc_hi,q} shifts right one place per step, absorbing the partial sum
        if (q[0]) begin
          acc_hi_nxt = {add_cout, add_sum[WIDTH-1:1]};
          q_nxt      = {add_sum[0], q[WIDTH-1:1]};
        end else begin
          acc_hi_nxt = {1'b0, acc_hi[WIDTH-1:1]};
          q_nxt      = {acc_hi[0], q[WIDTH-1:1]};
        end
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = sgn ? FIX_LO : DONE;
      end
      FIX_LO: begin
        add_a   = ~q;
        add_cin = 1'b1;
        if (neg) begin
          q_nxt = add_sum;
          c_nxt = add_cout;
        end else begin
          c_nxt = 1'b0;
        end
        state_nxt = FIX_HI;
      end
      FIX_HI: begin
        add_a   = ~acc_hi;
        add_cin = c;
        if (neg) acc_hi_nxt = add_sum;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle MULT/MULTU sequencer that time-shares one external 32-bit ripple adder (add_32) to form a 64-bit product into HI/LO.
- Sits beside the ALU in the execute path.
- Drives the adder's a/b/carry_in and consumes its sum/carry_out; the adder's overflow output is not used.
- Uses shift-add iteration. Signed operands are converted to magnitudes, and the result is negated at the end when needed, all through the same adder.

Parameters:
- WIDTH, 32, operand width; only 32 is supported. The iteration counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low; one clock, sampled on the rising edge of clk.
- start  input  1  request a multiply; sampled only when busy=0.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start.
- op_a  input  32  multiplicand; captured with start.
- op_b  input  32  multiplier; captured with start.
- add_a  output  32  adder operand a.
- add_b  output  32  adder operand b.
- add_cin  output  1  adder carry_in.
- add_sum  input  32  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry_out.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: hi/lo now hold a new result.
- hi  output  32  product bits 63:32 (registered).
- lo  output  32  product bits 31:0 (registered).

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, all internal registers 0.
  - Applies mid-operation too: the in-flight op is abandoned and no done pulse is produced.
- Adder drive: add_a/add_b/add_cin are 0 in IDLE and DONE, so no spurious toggling.
- States: IDLE, NEG_A, NEG_B, MUL, FIX_LO, FIX_HI, DONE.
- IDLE, busy=0. On start=1:
  - Capture M=op_a, Q=op_b, sgn=is_signed, neg=is_signed&(op_a[31]^op_b[31]).
  - Clear acc_hi and the counter.
  - Go to NEG_A if is_signed, else MUL.
- NEG_A: add_a=~M, add_b=0, add_cin=1. If M[31], M<=add_sum; else M holds. Next state NEG_B.
- NEG_B: same operation on Q. Next state MUL.
- MUL (exactly 32 cycles; the counter counts 0..31):
  - Drive add_a=acc_hi, add_b=M, add_cin=0.
  - If Q[0]=1: {acc_hi,Q} <= {add_cout, add_sum, Q[31:1]}.
  - Else: {acc_hi,Q} <= {1'b0, acc_hi, Q[31:1]}.
  - After counter=31: go to FIX_LO if sgn, else DONE.
- FIX_LO: add_a=~Q, add_b=0, add_cin=1. If neg: Q<=add_sum and latch c=add_cout. Else hold, c=0.
- FIX_HI: add_a=~acc_hi, add_b=0, add_cin=c. If neg, acc_hi<=add_sum. Next state DONE.
- DONE, single cycle:
  - hi<=acc_hi, lo<=Q registered on entry, so they are valid while done=1.
  - done=1, busy=0.
  - start in this cycle is accepted exactly as in IDLE (back-to-back); else next state is IDLE.
- busy=1 in NEG_A..FIX_HI. start while busy=1 is ignored; operands are not recaptured.
- Latency is fixed and independent of operand values (start sampled at edge 0):
  - Unsigned: done=1 in cycle 33.
  - Signed: done=1 in cycle 37 (negation cycles are always spent, even when no-op).
- hi/lo hold their last result until the next DONE; the intermediate accumulator is never visible on hi/lo.
- Boundary cases:
  - Negating 0x80000000 yields 0x80000000, which is correct as the unsigned magnitude 2^31.
  - Zero operands still take full latency.

Test Plan:
- Unsigned 3 x 5: start at edge 0 -> busy=1 cycles 1-32, done=1 only in cycle 33, hi=0x00000000, lo=0x0000000F.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at cycle 33; add_cout path exercised.
- Signed -3 x 5 (0xFFFFFFFD, 0x00000005) -> done cycle 37, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed -1 x -1 -> hi=0, lo=1. Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- Signed 7 x 6 (neg=0) -> still done at cycle 37, hi=0, lo=42.
- Control:
  - start pulsed with new operands at cycle 10 of an op -> ignored; result matches the original operands.
  - start in the DONE cycle -> a second op is accepted.
  - rst_n=0 at cycle 20 -> next cycle busy=0, hi=lo=0, no done pulse.
